// File: rtl/exe_pkg.sv
// Shared types and helpers for the RV32 execute stage.
package exe_pkg;

  // ALU / MD operation encoding as delivered by the ID/EXE register.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9,
    AluMul  = 4'd10,
    AluDiv  = 4'd11,
    AluDivu = 4'd12,
    AluRem  = 4'd13,
    AluRemu = 4'd14
  } alu_op_e;

  // Multiply/divide unit sequencing.
  typedef enum logic {
    MdIdle = 1'b0,
    MdBusy = 1'b1
  } md_state_e;

  // True for operations handled by the iterative multiply/divide unit.
  function automatic logic is_md(alu_op_e op);
    logic r;
    case (op)
      AluMul, AluDiv, AluDivu, AluRem, AluRemu: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the signed divide/remainder operations.
  function automatic logic is_signed_div(alu_op_e op);
    return (op == AluDiv) || (op == AluRem);
  endfunction

endpackage

// File: rtl/exe_stage_md_unit.sv
// Iterative shift-add multiplier and restoring divider.
// Takes MD_CYCLES busy cycles per operation; the final step is combinational
// so the result is presented with the done pulse in the last busy cycle.
module md_unit
  import exe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_rd,
  input  logic            i_wb_en,
  input  logic            i_abort,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_wb_en
);

  localparam int unsigned CntW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MD_CYCLES - 1);

  md_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  alu_op_e         r_op;
  logic [XLEN-1:0] r_acc;    // product accumulator / partial remainder
  logic [XLEN-1:0] r_x;      // multiplicand / dividend-then-quotient
  logic [XLEN-1:0] r_y;      // multiplier / divisor
  logic [XLEN-1:0] r_a;      // original dividend, returned as remainder on /0
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [4:0]      r_rd;
  logic            r_wb_en;

  logic            w_signed;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_last;
  logic [XLEN:0]   w_rem_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_acc_n;
  logic [XLEN-1:0] w_x_n;
  logic [XLEN-1:0] w_y_n;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;

  // Operand preparation at accept time: signed divides run on magnitudes.
  always_comb begin
    w_signed = is_signed_div(i_op);
    w_a_abs  = (w_signed && i_a[XLEN-1]) ? (~i_a + XLEN'(1)) : i_a;
    w_b_abs  = (w_signed && i_b[XLEN-1]) ? (~i_b + XLEN'(1)) : i_b;
  end

  // One iteration of either the shift-add multiply or the restoring divide.
  always_comb begin
    w_rem_shift = {r_acc, r_x[XLEN-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_y});
    // When w_ge holds the true difference is below 2^XLEN, so XLEN bits suffice.
    w_diff      = w_rem_shift[XLEN-1:0] - r_y;
    if (r_op == AluMul) begin
      w_acc_n = r_acc + (r_y[0] ? r_x : '0);
      w_x_n   = r_x << 1;
      w_y_n   = r_y >> 1;
    end else begin
      w_acc_n = w_ge ? w_diff : w_rem_shift[XLEN-1:0];
      w_x_n   = {r_x[XLEN-2:0], w_ge};
      w_y_n   = r_y;
    end
  end

  // Final sign fix-up and divide-by-zero override. Signed overflow
  // (MIN / -1) falls out of the magnitude path: |MIN|/1 = MIN, rem 0.
  always_comb begin
    w_quo = r_neg_q ? (~w_x_n + XLEN'(1)) : w_x_n;
    w_rem = r_neg_r ? (~w_acc_n + XLEN'(1)) : w_acc_n;
    case (r_op)
      AluMul:          o_result = w_acc_n;
      AluDiv, AluDivu: o_result = r_div0 ? '1 : w_quo;
      AluRem, AluRemu: o_result = r_div0 ? r_a : w_rem;
      default:         o_result = '0;
    endcase
  end

  assign w_last  = (r_cnt == LastCnt);
  assign o_busy  = (r_state == MdBusy);
  assign o_done  = o_busy && w_last && !i_abort;
  assign o_rd    = r_rd;
  assign o_wb_en = r_wb_en;

  // Sequencer and datapath registers: accept in idle, iterate while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MdIdle;
      r_cnt   <= '0;
      r_op    <= AluAdd;
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_rd    <= '0;
      r_wb_en <= 1'b0;
    end else begin
      case (r_state)
        MdIdle: begin
          if (i_start) begin
            r_state <= MdBusy;
            r_cnt   <= '0;
            r_op    <= i_op;
            r_acc   <= '0;
            r_x     <= w_a_abs;
            r_y     <= w_b_abs;
            r_a     <= i_a;
            r_neg_q <= w_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_r <= w_signed && i_a[XLEN-1];
            r_div0  <= (i_b == '0);
            r_rd    <= i_rd;
            r_wb_en <= i_wb_en;
          end
        end
        MdBusy: begin
          if (i_abort) begin
            r_state <= MdIdle;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_n;
            r_x   <= w_x_n;
            r_y   <= w_y_n;
            if (w_last) begin
              r_state <= MdIdle;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        default: begin
          r_state <= MdIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative MD unit, stall generation and
// the EXE/MEM pipeline register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_ex,
  input  logic            wb_en_ex,
  input  logic [4:0]      rd_addr_ex,
  input  logic [XLEN-1:0] rs1_data_reg,
  input  logic [XLEN-1:0] rs2_data_reg,
  input  logic [XLEN-1:0] imm_ex,
  input  logic            use_imm_ex,
  input  logic [3:0]      alu_op_ex,
  input  logic            flush_ex,
  output logic            stall_ex,
  output logic            valid_mem,
  output logic            wb_en_mem,
  output logic [4:0]      rd_addr_mem,
  output logic [XLEN-1:0] alu_out_mem
);

  alu_op_e         w_op;
  logic [XLEN-1:0] w_opb;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_md_req;
  logic            w_md_busy;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;
  logic [4:0]      w_md_rd;
  logic            w_md_wb_en;

  logic            r_valid;
  logic            r_wb_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu;

  assign w_op    = alu_op_e'(alu_op_ex);
  assign w_opb   = use_imm_ex ? imm_ex : rs2_data_reg;
  assign w_shamt = w_opb[4:0];

  // Single-cycle ALU result; MD encodings yield zero here.
  always_comb begin
    w_alu = '0;
    case (w_op)
      AluAdd:  w_alu = rs1_data_reg + w_opb;
      AluSub:  w_alu = rs1_data_reg - w_opb;
      AluAnd:  w_alu = rs1_data_reg & w_opb;
      AluOr:   w_alu = rs1_data_reg | w_opb;
      AluXor:  w_alu = rs1_data_reg ^ w_opb;
      AluSll:  w_alu = rs1_data_reg << w_shamt;
      AluSrl:  w_alu = rs1_data_reg >> w_shamt;
      AluSra:  w_alu = $signed(rs1_data_reg) >>> w_shamt;
      AluSlt:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_data_reg) < $signed(w_opb)};
      AluSltu: w_alu = {{(XLEN-1){1'b0}}, rs1_data_reg < w_opb};
      default: w_alu = '0;
    endcase
  end

  assign w_md_req = valid_ex && is_md(w_op) && !flush_ex;

  // A flush kills the instruction being held, so upstream is released at once.
  assign stall_ex = (!w_md_busy && w_md_req) || (w_md_busy && !flush_ex);

  md_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_md_unit (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_req),
    .i_op     (w_op),
    .i_a      (rs1_data_reg),
    .i_b      (w_opb),
    .i_rd     (rd_addr_ex),
    .i_wb_en  (wb_en_ex),
    .i_abort  (flush_ex),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result),
    .o_rd     (w_md_rd),
    .o_wb_en  (w_md_wb_en)
  );

  // EXE/MEM register: MD completion, bubbles on stall/flush, else ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wb_en <= 1'b0;
      r_rd    <= '0;
      r_alu   <= '0;
    end else if (w_md_done) begin
      r_valid <= 1'b1;
      r_wb_en <= w_md_wb_en;
      r_rd    <= w_md_rd;
      r_alu   <= w_md_result;
    end else if (stall_ex || flush_ex) begin
      r_valid <= 1'b0;
      r_wb_en <= 1'b0;
    end else begin
      r_valid <= valid_ex;
      r_wb_en <= wb_en_ex && valid_ex;
      r_rd    <= rd_addr_ex;
      r_alu   <= w_alu;
    end
  end

  assign valid_mem   = r_valid;
  assign wb_en_mem   = r_wb_en;
  assign rd_addr_mem = r_rd;
  assign alu_out_mem = r_alu;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU vectors, MD latency/results, flush, reset.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_ex;
  logic        wb_en_ex;
  logic [4:0]  rd_addr_ex;
  logic [31:0] rs1_data_reg;
  logic [31:0] rs2_data_reg;
  logic [31:0] imm_ex;
  logic        use_imm_ex;
  logic [3:0]  alu_op_ex;
  logic        flush_ex;
  logic        stall_ex;
  logic        valid_mem;
  logic        wb_en_mem;
  logic [4:0]  rd_addr_mem;
  logic [31:0] alu_out_mem;

  int n_vec = 0;
  int n_err = 0;

  exe_stage #(
    .XLEN      (32),
    .MD_CYCLES (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_ex     (valid_ex),
    .wb_en_ex     (wb_en_ex),
    .rd_addr_ex   (rd_addr_ex),
    .rs1_data_reg (rs1_data_reg),
    .rs2_data_reg (rs2_data_reg),
    .imm_ex       (imm_ex),
    .use_imm_ex   (use_imm_ex),
    .alu_op_ex    (alu_op_ex),
    .flush_ex     (flush_ex),
    .stall_ex     (stall_ex),
    .valid_mem    (valid_mem),
    .wb_en_mem    (wb_en_mem),
    .rd_addr_mem  (rd_addr_mem),
    .alu_out_mem  (alu_out_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wb, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic ui, input alu_op_e op, input logic fl);
    valid_ex     = v;
    wb_en_ex     = wb;
    rd_addr_ex   = rd;
    rs1_data_reg = a;
    rs2_data_reg = b;
    imm_ex       = imm;
    use_imm_ex   = ui;
    alu_op_ex    = op;
    flush_ex     = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, AluAdd, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, valid_mem}, 32'd0);
    chk({tag, ".wb"},    {31'd0, wb_en_mem}, 32'd0);
    chk({tag, ".rd"},    {27'd0, rd_addr_mem}, 32'd0);
    chk({tag, ".alu"},   alu_out_mem, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall_ex}, 32'd0);
  endtask

  // Single-cycle op: result one edge after it is presented.
  task automatic alu_vec(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic ui,
                         input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b1, rd, a, b, imm, ui, op, 1'b0);
    #1;
    chk({tag, ".stall"}, {31'd0, stall_ex}, 32'd0);
    tick();
    chk({tag, ".out"},   alu_out_mem, exp);
    chk({tag, ".valid"}, {31'd0, valid_mem}, 32'd1);
    chk({tag, ".wb"},    {31'd0, wb_en_mem}, 32'd1);
    chk({tag, ".rd"},    {27'd0, rd_addr_mem}, {27'd0, rd});
  endtask

  // MD op accepted in C0; stalls through C32; result visible in C33.
  task automatic md_vec(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b1, rd, a, b, 32'd0, 1'b0, op, 1'b0);
    #1;
    chk({tag, ".c0stall"}, {31'd0, stall_ex}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk({tag, ".busystall"}, {31'd0, stall_ex}, 32'd1);
      chk({tag, ".busyvalid"}, {31'd0, valid_mem}, 32'd0);
    end
    tick();
    idle_in();
    #1;
    chk({tag, ".out"},   alu_out_mem, exp);
    chk({tag, ".valid"}, {31'd0, valid_mem}, 32'd1);
    chk({tag, ".wb"},    {31'd0, wb_en_mem}, 32'd1);
    chk({tag, ".rd"},    {27'd0, rd_addr_mem}, {27'd0, rd});
    chk({tag, ".stall"}, {31'd0, stall_ex}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    alu_vec("add",  AluAdd,  32'd5,        32'd7,        32'd0, 1'b0, 5'd3, 32'd12);
    alu_vec("sra",  AluSra,  32'h8000_0000, 32'h0000_001F, 32'd4, 1'b1, 5'd4, 32'hF800_0000);
    alu_vec("sltu", AluSltu, 32'd1,        32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 32'd1);
    alu_vec("sub",  AluSub,  32'd5,        32'd7,        32'd0, 1'b0, 5'd6, 32'hFFFF_FFFE);
    alu_vec("slt",  AluSlt,  32'hFFFF_FFFF, 32'd1,        32'd0, 1'b0, 5'd7, 32'd1);
    alu_vec("sll",  AluSll,  32'd1,        32'd31,       32'd0, 1'b0, 5'd8, 32'h8000_0000);
    alu_vec("xor",  AluXor,  32'hF0F0_1234, 32'd0, 32'h0FF0_FFFF, 1'b1, 5'd0, 32'hFF00_EDCB);

    // Invalid slot and flush in idle both give a bubble.
    drive(1'b0, 1'b1, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0, AluAdd, 1'b0);
    tick();
    chk("novalid.valid", {31'd0, valid_mem}, 32'd0);
    chk("novalid.wb",    {31'd0, wb_en_mem}, 32'd0);
    drive(1'b1, 1'b1, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0, AluAdd, 1'b1);
    tick();
    chk("flushidle.valid", {31'd0, valid_mem}, 32'd0);

    md_vec("mul",   AluMul,  32'h0001_0000, 32'h0001_0001, 5'd10, 32'h0001_0000);
    md_vec("divov", AluDiv,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    md_vec("remu0", AluRemu, 32'd7,         32'd0,         5'd12, 32'd7);
    md_vec("divu0", AluDivu, 32'd7,         32'd0,         5'd13, 32'hFFFF_FFFF);
    md_vec("divn",  AluDiv,  32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD);
    md_vec("remn",  AluRem,  32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF);

    // Flush a DIVU while its counter is at 10.
    drive(1'b1, 1'b1, 5'd9, 32'd100, 32'd7, 32'd0, 1'b0, AluDivu, 1'b0);
    for (int k = 0; k < 11; k++) tick();
    chk("flush.prestall", {31'd0, stall_ex}, 32'd1);
    flush_ex = 1'b1;
    #1;
    chk("flush.stall", {31'd0, stall_ex}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("flush.valid", {31'd0, valid_mem}, 32'd0);
    chk("flush.after", {31'd0, stall_ex}, 32'd0);
    for (int k = 0; k < 24; k++) begin
      tick();
      chk("flush.nopulse", {31'd0, valid_mem}, 32'd0);
    end
    alu_vec("addpost", AluAdd, 32'd1, 32'd2, 32'd0, 1'b0, 5'd17, 32'd3);

    // Reset in the middle of a MUL.
    drive(1'b1, 1'b1, 5'd7, 32'd5, 32'd6, 32'd0, 1'b0, AluMul, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    chk_zero("midrst");
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("midrst.nopulse", {31'd0, valid_mem}, 32'd0);
    end
    md_vec("mul34", AluMul, 32'd3, 32'd4, 5'd1, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
